// File: rtl/cam_pkg.sv
// Shared constants and lane-FSM state type for the camera lane aligner.
package cam_pkg;

  localparam int unsigned      LaneW     = 8;
  localparam int unsigned      NumLanes  = 5;
  localparam logic [LaneW-1:0] TrainWord = 8'hE9;
  localparam logic [LaneW-1:0] CodeFs    = 8'hAA;
  localparam logic [LaneW-1:0] CodeLs    = 8'h2A;
  localparam logic [LaneW-1:0] CodeLe    = 8'h4A;
  localparam logic [LaneW-1:0] CodeFe    = 8'hCA;

  typedef enum logic [1:0] {
    StSearch,
    StSettle,
    StLocked,
    StFail
  } lane_st_e;

endpackage

// File: rtl/cam_lane_trainer.sv
// Per-lane word-alignment trainer: slips the deserializer until the training word is seen
// LOCK_COUNT times in a row, or gives up after MAX_SLIPS slips.
module cam_lane_trainer import cam_pkg::*; #(
  parameter logic [LaneW-1:0] TRAIN_WORD  = TrainWord,
  parameter int unsigned      LOCK_COUNT  = 16,
  parameter int unsigned      SLIP_SETTLE = 4,
  parameter int unsigned      MAX_SLIPS   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [LaneW-1:0] word_i,
  output logic             bitslip_o,
  output logic             locked_o,
  output logic             fail_o
);

  localparam logic [7:0] LockLast   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] SettleLast = 8'(SLIP_SETTLE - 1);
  localparam logic [7:0] SlipMax    = 8'(MAX_SLIPS);

  lane_st_e   state_q, state_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic       bitslip_q, bitslip_d;

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    settle_cnt_d = settle_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    bitslip_d    = 1'b0;
    if (!en_i) begin
      state_d      = StSearch;
      match_cnt_d  = '0;
      settle_cnt_d = '0;
      slip_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (word_i == TRAIN_WORD) begin
            if (match_cnt_q == LockLast) begin
              state_d     = StLocked;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = '0;
            if (slip_cnt_q == SlipMax) begin
              state_d = StFail;
            end else begin
              state_d      = StSettle;
              bitslip_d    = 1'b1;
              slip_cnt_d   = slip_cnt_q + 8'd1;
              settle_cnt_d = '0;
            end
          end
        end
        // Deserializer output is unstable right after a slip; ignore it for a while.
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            state_d      = StSearch;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        StLocked: state_d = StLocked;
        StFail:   state_d = StFail;
        default:  state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StSearch;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = (state_q == StLocked);
  assign fail_o    = (state_q == StFail);

endmodule

// File: rtl/cam_lane_align.sv
// Camera lane aligner: per-lane bitslip training, lock aggregation and sync-lane decode into
// frame/line strobes plus a pixel stream.
module cam_lane_align import cam_pkg::*; #(
  parameter int unsigned      NUM_LANES   = NumLanes,
  parameter logic [LaneW-1:0] TRAIN_WORD  = TrainWord,
  parameter int unsigned      LOCK_COUNT  = 16,
  parameter int unsigned      SLIP_SETTLE = 4,
  parameter int unsigned      MAX_SLIPS   = 16,
  parameter logic [LaneW-1:0] CODE_FS     = CodeFs,
  parameter logic [LaneW-1:0] CODE_LS     = CodeLs,
  parameter logic [LaneW-1:0] CODE_LE     = CodeLe,
  parameter logic [LaneW-1:0] CODE_FE     = CodeFe
) (
  input  logic                             c,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_LANES*LaneW-1:0]       rxd,
  output logic [NUM_LANES-1:0]             bitslip,
  output logic [NUM_LANES-1:0]             lane_locked,
  output logic                             aligned,
  output logic                             align_err,
  output logic                             sync_err,
  output logic [(NUM_LANES-1)*LaneW-1:0]   pix_data,
  output logic                             pix_valid,
  output logic                             frame_start,
  output logic                             line_start,
  output logic                             line_end,
  output logic                             frame_end
);

  localparam int unsigned PixW = (NUM_LANES - 1) * LaneW;

  logic [NUM_LANES-1:0] lane_fail;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    cam_lane_trainer #(
      .TRAIN_WORD  (TRAIN_WORD),
      .LOCK_COUNT  (LOCK_COUNT),
      .SLIP_SETTLE (SLIP_SETTLE),
      .MAX_SLIPS   (MAX_SLIPS)
    ) u_trainer (
      .clk_i     (c),
      .rst_i     (rst),
      .en_i      (en),
      .word_i    (rxd[k*LaneW +: LaneW]),
      .bitslip_o (bitslip[k]),
      .locked_o  (lane_locked[k]),
      .fail_o    (lane_fail[k])
    );
  end

  logic [LaneW-1:0] sync_word;
  assign sync_word = rxd[PixW +: LaneW];

  logic            aligned_q, aligned_d;
  logic            align_err_q, align_err_d;
  logic            sync_err_q, sync_err_d;
  logic            in_line_q, in_line_d;
  logic [PixW-1:0] pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            fs_q, fs_d, ls_q, ls_d, le_q, le_d, fe_q, fe_d;

  always_comb begin
    aligned_d   = en & (&lane_locked);
    align_err_d = align_err_q | (|lane_fail);
    sync_err_d  = sync_err_q;
    in_line_d   = in_line_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    fs_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    fe_d        = 1'b0;
    if (!en) begin
      in_line_d = 1'b0;
    end else if (aligned_q) begin
      pix_data_d = rxd[PixW-1:0];
      if (sync_word == CODE_FS) begin
        fs_d      = 1'b1;
        ls_d      = 1'b1;
        in_line_d = 1'b1;
        if (in_line_q) sync_err_d = 1'b1;
      end else if (sync_word == CODE_LS) begin
        ls_d      = 1'b1;
        in_line_d = 1'b1;
        if (in_line_q) sync_err_d = 1'b1;
      end else if (sync_word == CODE_LE) begin
        // An end code outside a line is dropped rather than forwarded.
        if (in_line_q) le_d = 1'b1;
        else           sync_err_d = 1'b1;
        in_line_d = 1'b0;
      end else if (sync_word == CODE_FE) begin
        if (in_line_q) begin
          le_d = 1'b1;
          fe_d = 1'b1;
        end else begin
          sync_err_d = 1'b1;
        end
        in_line_d = 1'b0;
      end else begin
        pix_valid_d = in_line_q;
      end
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      sync_err_q  <= 1'b0;
      in_line_q   <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      fs_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
      sync_err_q  <= sync_err_d;
      in_line_q   <= in_line_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      fs_q        <= fs_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      fe_q        <= fe_d;
    end
  end

  assign aligned     = aligned_q;
  assign align_err   = align_err_q;
  assign sync_err    = sync_err_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign frame_end   = fe_q;

endmodule

// File: tb/tb_cam_lane_align.sv
// Randomized bench for cam_lane_align: deserializer model with delayed bitslip rotation and a
// rule-level reference for lock timing and sync decode.
module tb_cam_lane_align;

  localparam int NL        = 5;
  localparam int LOCK      = 16;
  localparam int SETTLE    = 4;
  localparam int MAXS      = 16;
  localparam logic [7:0] TRAIN = 8'hE9;
  localparam logic [7:0] FS = 8'hAA, LS = 8'h2A, LE = 8'h4A, FE = 8'hCA;

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [39:0] rxd = '0;
  logic [4:0]  bitslip, lane_locked;
  logic        aligned, align_err, sync_err;
  logic [31:0] pix_data;
  logic        pix_valid, frame_start, line_start, line_end, frame_end;

  cam_lane_align dut (
    .c           (c),
    .rst         (rst),
    .en          (en),
    .rxd         (rxd),
    .bitslip     (bitslip),
    .lane_locked (lane_locked),
    .aligned     (aligned),
    .align_err   (align_err),
    .sync_err    (sync_err),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_end    (line_end),
    .frame_end   (frame_end)
  );

  always #5 c = ~c;

  int n_cmp = 0;
  int n_err = 0;

  int         off   [NL];
  bit         dead  [NL];
  logic [7:0] dconst[NL];
  bit         m_in_line;
  bit         m_sync_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [15:0] d;
    d = {w, w};
    return d[15-n -: 8];
  endfunction

  function automatic bit is_train_rot(input logic [7:0] w);
    for (int i = 0; i < 8; i++) if (rotl(TRAIN, i) == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_rxd();
    for (int k = 0; k < NL; k++) rxd[k*8 +: 8] = dead[k] ? dconst[k] : rotl(TRAIN, off[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    rxd = '0;
    repeat (2) @(posedge c);
    #1;
    check("reset", 64'({bitslip, lane_locked, aligned, align_err, sync_err, pix_data, pix_valid,
                        frame_start, line_start, line_end, frame_end}), 64'd0);
    rst = 1'b0;
    m_in_line  = 1'b0;
    m_sync_err = 1'b0;
  endtask

  // Expected lock time: each needed slip costs one mismatch sample plus the settle window.
  task automatic train_trial(input string name, input int budget);
    int exp_pulses[NL], exp_lock[NL], pulses[NL], lock_cyc[NL], last[NL], due[NL];
    bit gap_ok[NL];
    int exp_al, al_cyc, worst;
    bit any_dead;
    do_reset();
    any_dead = 1'b0;
    worst    = 0;
    for (int k = 0; k < NL; k++) begin
      if (dead[k]) begin
        exp_pulses[k] = MAXS;
        exp_lock[k]   = -1;
        any_dead      = 1'b1;
      end else begin
        exp_pulses[k] = (8 - off[k]) % 8;
        exp_lock[k]   = exp_pulses[k] * (SETTLE + 1) + LOCK;
        if (exp_lock[k] > worst) worst = exp_lock[k];
      end
      pulses[k] = 0; lock_cyc[k] = -1; last[k] = -1; due[k] = -1; gap_ok[k] = 1'b1;
    end
    exp_al = any_dead ? -1 : worst + 1;
    al_cyc = -1;
    en = 1'b1;
    drive_rxd();
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge c);
      #1;
      for (int k = 0; k < NL; k++) begin
        if (bitslip[k]) begin
          pulses[k]++;
          if (last[k] >= 0 && cyc - last[k] - 1 < SETTLE) gap_ok[k] = 1'b0;
          last[k] = cyc;
          due[k]  = cyc + 2;
        end
        if (lane_locked[k] && lock_cyc[k] < 0) lock_cyc[k] = cyc;
        if (due[k] == cyc) begin
          off[k] = (off[k] + 1) % 8;
          due[k] = -1;
        end
      end
      if (aligned && al_cyc < 0) al_cyc = cyc;
      drive_rxd();
    end
    for (int k = 0; k < NL; k++) begin
      check($sformatf("%s pulses%0d", name, k), 64'(pulses[k]), 64'(exp_pulses[k]));
      check($sformatf("%s lock%0d", name, k), 64'(lock_cyc[k]), 64'(exp_lock[k]));
      check($sformatf("%s gap%0d", name, k), 64'(gap_ok[k]), 64'd1);
    end
    check({name, " aligned_cyc"}, 64'(al_cyc), 64'(exp_al));
    check({name, " align_err"}, 64'(align_err), 64'(any_dead));
    check({name, " sync_err"}, 64'(sync_err), 64'd0);
  endtask

  task automatic send(input logic [7:0] sw, input logic [31:0] px);
    bit e_fs, e_ls, e_le, e_fe, e_pv;
    rxd = {sw, px};
    {e_fs, e_ls, e_le, e_fe, e_pv} = '0;
    if (sw == FS) begin
      e_fs = 1; e_ls = 1;
      if (m_in_line) m_sync_err = 1;
      m_in_line = 1;
    end else if (sw == LS) begin
      e_ls = 1;
      if (m_in_line) m_sync_err = 1;
      m_in_line = 1;
    end else if (sw == LE) begin
      if (m_in_line) e_le = 1; else m_sync_err = 1;
      m_in_line = 0;
    end else if (sw == FE) begin
      if (m_in_line) begin e_le = 1; e_fe = 1; end else m_sync_err = 1;
      m_in_line = 0;
    end else begin
      e_pv = m_in_line;
    end
    @(posedge c);
    #1;
    check($sformatf("decode sw=%0h", sw),
          64'({frame_start, line_start, line_end, frame_end, pix_valid, sync_err}),
          64'({e_fs, e_ls, e_le, e_fe, e_pv, m_sync_err}));
    if (e_pv) check($sformatf("pix sw=%0h", sw), 64'(pix_data), 64'(px));
  endtask

  task automatic all_good();
    for (int k = 0; k < NL; k++) begin
      off[k] = 0; dead[k] = 1'b0; dconst[k] = 8'h00;
    end
  endtask

  initial begin
    int al;
    logic [7:0] sw;

    // Pre-aligned lanes.
    all_good();
    train_trial("prealigned", 60);

    // Lane 2 needs three slips.
    all_good();
    off[2] = 5;
    train_trial("lane2_rot", 80);

    // Lane 0 stuck at zero; align_err must survive an en drop and clear only on rst.
    all_good();
    dead[0] = 1'b1;
    train_trial("lane0_dead", 100);
    en = 1'b0;
    @(posedge c);
    #1;
    check("align_err sticky", 64'(align_err), 64'd1);
    en = 1'b1;
    @(posedge c);
    #1;
    check("align_err sticky2", 64'(align_err), 64'd1);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NL; k++) begin
        off[k]  = $urandom_range(0, 7);
        dead[k] = ($urandom_range(0, 5) == 0);
        do dconst[k] = 8'($urandom); while (is_train_rot(dconst[k]));
      end
      train_trial($sformatf("rand%0d", t), 100);
    end

    // Sync decode after a clean alignment.
    all_good();
    train_trial("decode_train", 30);
    send(FS, 32'h0);
    send(8'h00, 32'h11223344);
    send(8'h00, 32'h55667788);
    send(8'h00, 32'h99AABBCC);
    send(LE, 32'h0);
    send(LS, 32'h0);
    send(8'h13, 32'hDEADBEEF);
    send(FE, 32'h0);
    check("sync_err clean", 64'(sync_err), 64'd0);
    send(LE, 32'h0);
    send(LS, 32'h0);
    send(LS, 32'h0);
    check("sync_err set", 64'(sync_err), 64'd1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: sw = FS;
        1: sw = LS;
        2: sw = LE;
        3: sw = FE;
        default: sw = 8'($urandom);
      endcase
      send(sw, $urandom);
    end

    // Drop en mid-line.
    send(LS, 32'h0);
    en = 1'b0;
    rxd = {5{TRAIN}};
    @(posedge c);
    #1;
    m_in_line = 1'b0;
    check("endrop aligned", 64'(aligned), 64'd0);
    check("endrop pix_valid", 64'(pix_valid), 64'd0);
    check("endrop locked", 64'(lane_locked), 64'd0);
    check("endrop sync_err", 64'(sync_err), 64'(m_sync_err));
    check("endrop align_err", 64'(align_err), 64'd0);
    en = 1'b1;
    al = -1;
    for (int cyc = 1; cyc <= 40 && al < 0; cyc++) begin
      @(posedge c);
      #1;
      if (aligned) al = cyc;
    end
    check("retrain aligned_cyc", 64'(al), 64'(LOCK + 1));
    send(8'h00, 32'h12345678);
    rst = 1'b1;
    @(posedge c);
    #1;
    check("rst clears errs", 64'({sync_err, align_err}), 64'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
